// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared LC-3b types for the pipeline sequencing logic: register
// specifiers and the hazard controller's indirect-access state.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [1:0] {
        HZ_RUN  = 2'd0,
        HZ_IND1 = 2'd1,
        HZ_IND2 = 2'd2
    } lc3b_hazard_state;

endpackage

// File: rtl/pipeline_hazard_controller_resp.sv
// Holds a one-cycle cache response that arrives while the pipe is frozen,
// so the consumer still sees it once the pipe is allowed to advance.
module resp_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic resp_i,
    input  logic freeze_i,
    output logic done_o
);

    logic done_q;

    // Set on a response seen while frozen; drop on the first advancing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (!freeze_i) begin
            done_q <= 1'b0;
        end else if (resp_i) begin
            done_q <= 1'b1;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing controller: generates every pipeline-register load and
// flush, the PC enable, the two-access LDI/STI sequence, and two saturating
// performance counters (freeze cycles and load-use bubbles).
module pipeline_hazard_controller
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  lc3b_reg          id_sr1,
    input  lc3b_reg          id_sr2,
    input  logic             id_uses_sr2,
    input  lc3b_reg          exec_dest,
    input  logic             exec_reg_write,
    input  logic             exec_mem_read,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             mem_indirect,
    input  logic             branch_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             ind_ptr_load,
    output logic             ind_second,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count
);

    lc3b_hazard_state state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic imem_done, dmem_done;
    logic imem_ready, dmem_ready;
    logic ind_start;
    logic freeze;
    logic load_use;
    logic bubble_now;
    logic dmem_set;

    assign imem_ready = imem_resp | imem_done;
    assign dmem_ready = dmem_resp | dmem_done;
    assign ind_start  = mem_indirect & dmem_req & ~dmem_done;

    assign freeze = (imem_req & ~imem_ready)
                  | (dmem_req & ~dmem_ready & ~mem_indirect)
                  | ind_start
                  | (state_q != HZ_RUN);

    assign load_use = exec_mem_read & exec_reg_write &
                      ((exec_dest == id_sr1) | (id_uses_sr2 & (exec_dest == id_sr2)));

    // A taken branch outranks the load-use bubble, so no bubble is counted then.
    assign bubble_now = ~freeze & ~branch_taken & load_use;

    // The pointer-word response of an indirect access must not mark the
    // D-side done; only the final (data) response or a plain access does.
    assign dmem_set = dmem_resp & ~ind_ptr_load;

    resp_latch u_imem_latch (
        .clk      (clk),
        .rst_n    (rst_n),
        .resp_i   (imem_resp),
        .freeze_i (freeze),
        .done_o   (imem_done)
    );

    resp_latch u_dmem_latch (
        .clk      (clk),
        .rst_n    (rst_n),
        .resp_i   (dmem_set),
        .freeze_i (freeze),
        .done_o   (dmem_done)
    );

    // State and counter registers; reset aborts any indirect sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HZ_RUN;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    // Indirect-access sequencing: pointer response, then data response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HZ_RUN: begin
                if (ind_start) begin
                    state_d = dmem_resp ? HZ_IND2 : HZ_IND1;
                end
            end
            HZ_IND1: begin
                if (dmem_resp) begin
                    state_d = HZ_IND2;
                end
            end
            HZ_IND2: begin
                if (dmem_resp) begin
                    state_d = HZ_RUN;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    // Saturating performance counters.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (freeze && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
        if (bubble_now && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    // Pipeline enables, flushes and indirect-access controls.
    always_comb begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        ind_ptr_load = 1'b0;
        ind_second   = 1'b0;
        if (!rst_n) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else begin
            ind_second   = (state_q == HZ_IND2);
            ind_ptr_load = dmem_resp &
                           (((state_q == HZ_RUN) & ind_start) | (state_q == HZ_IND1));
            if (!freeze) begin
                if (branch_taken) begin
                    load_pc      = 1'b1;
                    load_if_id   = 1'b1;
                    load_id_ex   = 1'b1;
                    load_ex_mem  = 1'b1;
                    load_mem_wb  = 1'b1;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                end else if (load_use) begin
                    load_id_ex   = 1'b1;
                    load_ex_mem  = 1'b1;
                    load_mem_wb  = 1'b1;
                    flush_id_ex  = 1'b1;
                end else begin
                    load_pc      = 1'b1;
                    load_if_id   = 1'b1;
                    load_id_ex   = 1'b1;
                    load_ex_mem  = 1'b1;
                    load_mem_wb  = 1'b1;
                end
            end
        end
    end

    assign stall_cycles = stall_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed test of the hazard controller. Control outputs are grouped as
// {load_pc,load_if_id,load_id_ex,load_ex_mem,load_mem_wb,
//  flush_if_id,flush_id_ex,flush_ex_mem,ind_ptr_load,ind_second}.
module tb_pipeline_hazard_controller;
    import lc3b_types::*;

    localparam int CW = 4;

    localparam logic [9:0] C_RUN  = 10'b11111_000_00;
    localparam logic [9:0] C_FRZ  = 10'b00000_000_00;
    localparam logic [9:0] C_LU   = 10'b00111_010_00;
    localparam logic [9:0] C_BR   = 10'b11111_111_00;
    localparam logic [9:0] C_RST  = 10'b00000_111_00;
    localparam logic [9:0] C_PTR  = 10'b00000_000_10;
    localparam logic [9:0] C_IND2 = 10'b00000_000_01;

    logic clk = 1'b0;
    logic rst_n;
    lc3b_reg id_sr1, id_sr2, exec_dest;
    logic id_uses_sr2, exec_reg_write, exec_mem_read;
    logic imem_req, imem_resp, dmem_req, dmem_resp, mem_indirect, branch_taken;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mem, ind_ptr_load, ind_second;
    logic [CW-1:0] stall_cycles, bubble_count;
    logic [9:0] ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_sr1         (id_sr1),
        .id_sr2         (id_sr2),
        .id_uses_sr2    (id_uses_sr2),
        .exec_dest      (exec_dest),
        .exec_reg_write (exec_reg_write),
        .exec_mem_read  (exec_mem_read),
        .imem_req       (imem_req),
        .imem_resp      (imem_resp),
        .dmem_req       (dmem_req),
        .dmem_resp      (dmem_resp),
        .mem_indirect   (mem_indirect),
        .branch_taken   (branch_taken),
        .load_pc        (load_pc),
        .load_if_id     (load_if_id),
        .load_id_ex     (load_id_ex),
        .load_ex_mem    (load_ex_mem),
        .load_mem_wb    (load_mem_wb),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .flush_ex_mem   (flush_ex_mem),
        .ind_ptr_load   (ind_ptr_load),
        .ind_second     (ind_second),
        .stall_cycles   (stall_cycles),
        .bubble_count   (bubble_count)
    );

    assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, ind_ptr_load, ind_second};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Check the control outputs mid-cycle, then advance past the next edge.
    task automatic cyc(input string tag, input logic [9:0] exp);
        @(negedge clk);
        chk(tag, {22'd0, ctl}, {22'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_sr1 = 3'd0; id_sr2 = 3'd0; id_uses_sr2 = 1'b0; exec_dest = 3'd7;
        exec_reg_write = 1'b0; exec_mem_read = 1'b0;
        imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
        mem_indirect = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk("reset_ctl", {22'd0, ctl}, {22'd0, C_RST});
        chk("reset_stall", {28'd0, stall_cycles}, 32'd0);
        chk("reset_bubble", {28'd0, bubble_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        cyc("idle_run", C_RUN);

        // Load-use: LDR R1 in EX, ADD reading R1 as sr2.
        exec_mem_read = 1'b1; exec_reg_write = 1'b1; exec_dest = 3'd1;
        id_sr1 = 3'd3; id_sr2 = 3'd1; id_uses_sr2 = 1'b1;
        cyc("loaduse_bubble", C_LU);
        chk("loaduse_count", {28'd0, bubble_count}, 32'd1);
        // Same match on sr2 but immediate form: no hazard.
        id_uses_sr2 = 1'b0;
        cyc("imm_no_hazard", C_RUN);
        chk("imm_count", {28'd0, bubble_count}, 32'd1);
        idle_inputs();

        // I-miss: response arrives on the 4th cycle.
        imem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("imiss_frozen", C_FRZ);
        imem_resp = 1'b1;
        cyc("imiss_resp", C_RUN);
        chk("imiss_stall", {28'd0, stall_cycles}, 32'd3);
        idle_inputs();

        // Early imem response during a D-miss is remembered.
        imem_req = 1'b1; imem_resp = 1'b1; dmem_req = 1'b1;
        cyc("early_i_frozen", C_FRZ);
        imem_resp = 1'b0;
        cyc("early_i_wait", C_FRZ);
        dmem_resp = 1'b1;
        cyc("early_i_adv", C_RUN);
        chk("early_i_stall", {28'd0, stall_cycles}, 32'd5);
        // Flag consumed: a new fetch without response freezes again.
        dmem_req = 1'b0; dmem_resp = 1'b0;
        cyc("flag_cleared", C_FRZ);
        imem_resp = 1'b1;
        cyc("refetch_ok", C_RUN);
        idle_inputs();

        // LDI: pointer response on cycle 1, data on cycle 3; an imem
        // response during the sequence is held until it ends.
        mem_indirect = 1'b1; dmem_req = 1'b1;
        cyc("ldi_start", C_FRZ);
        dmem_resp = 1'b1;
        cyc("ldi_ptr", C_PTR);
        dmem_resp = 1'b0; imem_req = 1'b1; imem_resp = 1'b1;
        cyc("ldi_ind2_wait", C_IND2);
        imem_resp = 1'b0; dmem_resp = 1'b1;
        cyc("ldi_data", C_IND2);
        dmem_resp = 1'b0;
        cyc("ldi_done", C_RUN);
        chk("ldi_stall", {28'd0, stall_cycles}, 32'd10);
        idle_inputs();

        // Branch waits out a D-miss, then flushes for one cycle.
        dmem_req = 1'b1; branch_taken = 1'b1;
        cyc("br_frozen0", C_FRZ);
        cyc("br_frozen1", C_FRZ);
        dmem_resp = 1'b1;
        cyc("br_flush", C_BR);
        chk("br_stall", {28'd0, stall_cycles}, 32'd12);
        idle_inputs();
        cyc("br_after", C_RUN);

        // Branch together with load-use: flush only, no bubble counted.
        branch_taken = 1'b1; exec_mem_read = 1'b1; exec_reg_write = 1'b1;
        exec_dest = 3'd2; id_sr1 = 3'd2;
        cyc("br_over_lu", C_BR);
        chk("br_over_lu_cnt", {28'd0, bubble_count}, 32'd1);
        idle_inputs();

        // Zero-wait pointer response, then reset while in HZ_IND2.
        mem_indirect = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1;
        cyc("ind_zero_wait", C_PTR);
        chk("ind_stall", {28'd0, stall_cycles}, 32'd13);
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("ind2_state", {22'd0, ctl}, {22'd0, C_IND2});
        dmem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {22'd0, ctl}, {22'd0, C_RST});
        chk("midrst_stall", {28'd0, stall_cycles}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b1;
        imem_req = 1'b1; imem_resp = 1'b1;
        cyc("post_rst_fetch", C_RUN);
        chk("post_rst_stall", {28'd0, stall_cycles}, 32'd0);

        // Saturation of the 4-bit stall counter.
        imem_resp = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
        end
        chk("stall_saturate", {28'd0, stall_cycles}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
